dispensador_bebida: RTL and testbench

Recipe sequencer that consumes the 3-bit drink code from the drink-selection stage and sequences the dispensing valves. On a start request it latches the code and opens each ingredient valve (coffee, water, milk, chocolate) for a fixed number of time ticks. Valves are driven one at a time, then the block pulses done. It sits between drink selection and the valve/relay drivers.

---
 rtl/dispensador_bebida.sv | 142 ++++++++++++++
 tb/tb_dispensador_bebida.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_bebida.sv
// Recipe sequencer: latches a drink code and opens the ingredient valves one at a time,
// each for a fixed number of prescaled ticks, then pulses done.
module dispensador_bebida #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] c_type,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] valves,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    type_q, type_d;
    logic [1:0]    stage_q, stage_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    valves_q, valves_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [2:0]    first_nz, next_nz;

    // Stage index: 0 coffee, 1 water, 2 milk, 3 choc
    function automatic logic [2:0] dur_f(input logic [2:0] t, input logic [1:0] s);
        case ({t, s})
            5'b001_00: dur_f = 3'd4;
            5'b001_01: dur_f = 3'd2;
            5'b010_00: dur_f = 3'd4;
            5'b010_01: dur_f = 3'd6;
            5'b011_00: dur_f = 3'd4;
            5'b011_10: dur_f = 3'd4;
            5'b100_00: dur_f = 3'd4;
            5'b100_10: dur_f = 3'd3;
            5'b100_11: dur_f = 3'd2;
            default:   dur_f = 3'd0;
        endcase
    endfunction

    function automatic logic valid_f(input logic [2:0] t);
        valid_f = (t >= 3'd1) && (t <= 3'd4);
    endfunction

    // {found, index} of the lowest non-zero stage at or after 'from'
    function automatic logic [2:0] find_nz(input logic [2:0] t, input logic [2:0] from);
        find_nz = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && dur_f(t, 2'(i)) != 3'd0) find_nz = {1'b1, 2'(i)};
        end
    endfunction

    assign first_nz = find_nz(c_type, 3'd0);
    assign next_nz  = find_nz(type_q, {1'b0, stage_q} + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            type_q   <= 3'd0;
            stage_q  <= 2'd0;
            cnt_q    <= 3'd0;
            pre_q    <= '0;
            valves_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            valves_q <= valves_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort && valid_f(c_type)) begin
                    type_d  = c_type;
                    stage_d = first_nz[1:0];
                    cnt_d   = dur_f(c_type, first_nz[1:0]);
                    pre_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    pre_d   = '0;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    // Last tick of a stage hands over to the next one on the same edge
                    if (cnt_q <= 3'd1) begin
                        if (next_nz[2]) begin
                            stage_d = next_nz[1:0];
                            cnt_d   = dur_f(type_q, next_nz[1:0]);
                        end else begin
                            cnt_d   = 3'd0;
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_comb begin
        valves_d = (state_d == S_RUN) ? (4'd1 << stage_d) : 4'd0;
        busy_d   = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
        err_d    = (state_q == S_IDLE) && start && !abort && !valid_f(c_type);
    end

    assign valves = valves_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
endmodule

// File: tb/tb_dispensador_bebida.sv
// Directed bench: a TICK_DIV=4 instance for most scenarios, a TICK_DIV=1 instance for held-start runs.
module tb_dispensador_bebida;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] c4 = 3'd0, c1 = 3'd0;
    logic       st4 = 1'b0, st1 = 1'b0, ab4 = 1'b0, ab1 = 1'b0;
    logic [3:0] v4, v1;
    logic       b4, b1, d4, d1, e4, e1;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    dispensador_bebida #(.TICK_DIV(4)) u4 (
        .clk(clk), .rst_n(rst_n), .c_type(c4), .start(st4), .abort(ab4),
        .valves(v4), .busy(b4), .done(d4), .err(e4)
    );
    dispensador_bebida #(.TICK_DIV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .c_type(c1), .start(st1), .abort(ab1),
        .valves(v1), .busy(b1), .done(d1), .err(e1)
    );

    // Observed word is {valves, busy, done, err}
    task automatic test_reset();
        #2;
        vectors++;
        if ({v4, b4, d4, e4} !== 7'b0 || {v1, b1, d1, e1} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset obs4=%b obs1=%b exp=0000000", {v4, b4, d4, e4}, {v1, b1, d1, e1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({v4, b4, d4, e4} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_release obs=%b exp=0000000", {v4, b4, d4, e4});
        end
    endtask

    task automatic test_espresso();
        logic [6:0] exp;
        c4 = 3'b001; st4 = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            st4 = 1'b0;
            if (c <= 16)      exp = 7'b0001_100;
            else if (c <= 24) exp = 7'b0010_100;
            else if (c == 25) exp = 7'b0000_010;
            else              exp = 7'b0000_000;
            vectors++;
            if ({v4, b4, d4, e4} !== exp) begin
                miscompares++;
                $display("FAIL espresso cyc=%0d obs=%b exp=%b", c, {v4, b4, d4, e4}, exp);
            end
        end
    endtask

    task automatic test_mocha();
        logic [6:0] exp;
        c4 = 3'b100; st4 = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            st4 = 1'b0;
            if (c <= 16)      exp = 7'b0001_100;
            else if (c <= 28) exp = 7'b0100_100;
            else if (c <= 36) exp = 7'b1000_100;
            else if (c == 37) exp = 7'b0000_010;
            else              exp = 7'b0000_000;
            vectors++;
            if ({v4, b4, d4, e4} !== exp) begin
                miscompares++;
                $display("FAIL mocha cyc=%0d obs=%b exp=%b", c, {v4, b4, d4, e4}, exp);
            end
        end
    endtask

    task automatic test_invalid();
        logic [2:0] codes [2];
        codes[0] = 3'b000; codes[1] = 3'b101;
        for (int k = 0; k < 2; k++) begin
            c4 = codes[k]; st4 = 1'b1;
            @(negedge clk);
            st4 = 1'b0;
            vectors++;
            if ({v4, b4, d4, e4} !== 7'b0000_001) begin
                miscompares++;
                $display("FAIL invalid_err code=%b obs=%b exp=0000001", codes[k], {v4, b4, d4, e4});
            end
            @(negedge clk);
            vectors++;
            if ({v4, b4, d4, e4} !== 7'b0) begin
                miscompares++;
                $display("FAIL invalid_clear code=%b obs=%b exp=0000000", codes[k], {v4, b4, d4, e4});
            end
        end
        // Held invalid start: one err pulse per sampled cycle
        c4 = 3'b111; st4 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) st4 = 1'b0;
            vectors++;
            if ({v4, b4, d4, e4} !== ((c <= 3) ? 7'b0000_001 : 7'b0)) begin
                miscompares++;
                $display("FAIL invalid_held cyc=%0d obs=%b", c, {v4, b4, d4, e4});
            end
        end
        // Start together with abort is ignored, valid code or not
        c4 = 3'b010; st4 = 1'b1; ab4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0; ab4 = 1'b0;
        vectors++;
        if ({v4, b4, d4, e4} !== 7'b0) begin
            miscompares++;
            $display("FAIL start_with_abort obs=%b exp=0000000", {v4, b4, d4, e4});
        end
    endtask

    task automatic test_abort();
        logic [6:0] exp;
        c4 = 3'b011; st4 = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            st4 = 1'b0; ab4 = 1'b0;
            if (c <= 16)      exp = 7'b0001_100;
            else if (c <= 22) exp = 7'b0100_100;
            else              exp = 7'b0000_000;
            vectors++;
            if ({v4, b4, d4, e4} !== exp) begin
                miscompares++;
                $display("FAIL abort cyc=%0d obs=%b exp=%b", c, {v4, b4, d4, e4}, exp);
            end
            if (c == 19) begin c4 = 3'b001; st4 = 1'b1; end
            if (c == 22) ab4 = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] exp;
        c4 = 3'b011; st4 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            st4 = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({v4, b4, d4, e4} !== 7'b0) begin
            miscompares++;
            $display("FAIL async_reset obs=%b exp=0000000", {v4, b4, d4, e4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        c4 = 3'b010; st4 = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            st4 = 1'b0;
            if (c <= 16)      exp = 7'b0001_100;
            else if (c <= 40) exp = 7'b0010_100;
            else if (c == 41) exp = 7'b0000_010;
            else              exp = 7'b0000_000;
            vectors++;
            if ({v4, b4, d4, e4} !== exp) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d obs=%b exp=%b", c, {v4, b4, d4, e4}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        int p;
        c1 = 3'b010; st1 = 1'b1;
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            p = k % 12;
            if (k == 36)     exp = 7'b0000_000;
            else if (p < 4)  exp = 7'b0001_100;
            else if (p < 10) exp = 7'b0010_100;
            else if (p == 10) exp = 7'b0000_010;
            else             exp = 7'b0000_000;
            vectors++;
            if ({v1, b1, d1, e1} !== exp) begin
                miscompares++;
                $display("FAIL back_to_back k=%0d obs=%b exp=%b", k, {v1, b1, d1, e1}, exp);
            end
            if (k == 35) st1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_espresso();
        test_mocha();
        test_invalid();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
